// File: rtl/proc_bus_pkg.sv
// proc_bus_pkg: shared types and constants for the byte/word merge and split paths.
package proc_bus_pkg;
  localparam int SPLIT_BYTE_WIDTH = 8;
  localparam int SPLIT_WORD_WIDTH = 2 * SPLIT_BYTE_WIDTH;
  localparam logic ORDER_MSB_FIRST = 1'b1;
  localparam logic ORDER_LSB_FIRST = 1'b0;
  typedef enum logic [1:0] {SPLIT_IDLE, SPLIT_FIRST, SPLIT_SECOND} split_state_e;
endpackage

// File: rtl/word_splitter_16to8_byte_select.sv
// byte_select: picks the byte of a held word presented in a given split state and byte order.
module byte_select
  import proc_bus_pkg::*;
#(
  parameter int BYTE_WIDTH = SPLIT_BYTE_WIDTH
) (
  input  split_state_e            state,
  input  logic                    order,
  input  logic [2*BYTE_WIDTH-1:0] word,
  output logic [BYTE_WIDTH-1:0]   sel
);
  logic hi;
  assign hi  = (state == SPLIT_FIRST) == (order == ORDER_MSB_FIRST);
  assign sel = state == SPLIT_IDLE ? '0 : hi ? word[2*BYTE_WIDTH-1:BYTE_WIDTH] : word[BYTE_WIDTH-1:0];
endmodule

// File: rtl/word_splitter_16to8.sv
// word_splitter_16to8: emits each accepted 16-bit word as two bytes on a valid/ready stream.
// Define SPLIT_PARITY_EN to add the outParity bus-parity output.
module word_splitter_16to8
  import proc_bus_pkg::*;
#(
  parameter int BYTE_WIDTH  = SPLIT_BYTE_WIDTH,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [2*BYTE_WIDTH-1:0] inWord,
  input  logic                    inMsbFirst,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [BYTE_WIDTH-1:0]   outByte,
  output logic                    outLast,
`ifdef SPLIT_PARITY_EN
  output logic                    outParity,
`endif
  output logic [COUNT_WIDTH-1:0]  wordCount
);
  split_state_e state, state_nxt;
  logic [2*BYTE_WIDTH-1:0] hold;
  logic order, in_xfer, out_xfer;
  assign in_xfer  = inValid && inReady;
  assign out_xfer = outValid && outReady;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= SPLIT_IDLE;
    else state <= state_nxt;
  // An in-transfer is only possible from IDLE or a completing SECOND, so it always lands in FIRST.
  always_comb begin
    state_nxt = in_xfer ? SPLIT_FIRST : !out_xfer ? state :
                state == SPLIT_FIRST ? SPLIT_SECOND : SPLIT_IDLE;
  end
  always_comb begin
    outValid = state != SPLIT_IDLE;
    outLast  = state == SPLIT_SECOND;
    inReady  = resetN && (state == SPLIT_IDLE || (state == SPLIT_SECOND && outReady));
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hold  <= '0;
      order <= ORDER_LSB_FIRST;
    end else if (in_xfer) begin
      hold  <= inWord;
      order <= inMsbFirst;
    end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) wordCount <= '0;
    else if (out_xfer && state == SPLIT_SECOND) wordCount <= wordCount + COUNT_WIDTH'(1);
  byte_select #(.BYTE_WIDTH(BYTE_WIDTH)) u_sel (
    .state(state),
    .order(order),
    .word (hold),
    .sel  (outByte)
  );
`ifdef SPLIT_PARITY_EN
  assign outParity = ^outByte;
`endif
endmodule

// File: tb/tb_word_splitter_16to8.sv
// tb_word_splitter_16to8: directed vector table plus hand-written sequences for the splitter.
module tb_word_splitter_16to8;
  logic clk = 1'b0, resetN = 1'b0, inValid = 1'b0, inMsbFirst = 1'b0, outReady = 1'b0;
  logic [15:0] inWord = '0;
  logic inReady, outValid, outLast;
  logic [7:0] outByte, wordCount;
`ifdef SPLIT_PARITY_EN
  logic outParity;
`endif
  int n_chk = 0, n_fail = 0;
  logic [7:0] cnt = '0;
  logic [7:0] prev;
  typedef struct packed {logic [15:0] w; logic msb; logic [7:0] b1, b2; logic p1, p2;} vec_t;
  vec_t vecs[7];
  logic [7:0] b2b_exp[6];
  logic [15:0] b2b_words[3];
  word_splitter_16to8 dut (
    .clk       (clk),
    .resetN    (resetN),
    .inValid   (inValid),
    .inReady   (inReady),
    .inWord    (inWord),
    .inMsbFirst(inMsbFirst),
    .outValid  (outValid),
    .outReady  (outReady),
    .outByte   (outByte),
    .outLast   (outLast),
`ifdef SPLIT_PARITY_EN
    .outParity (outParity),
`endif
    .wordCount (wordCount)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{16'h1234, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1};
    vecs[1] = '{16'hBEEF, 1'b0, 8'hEF, 8'hBE, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{16'hA55A, 1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{16'h0102, 1'b0, 8'h02, 8'h01, 1'b1, 1'b1};
    vecs[6] = '{16'h0703, 1'b1, 8'h07, 8'h03, 1'b1, 1'b0};
    b2b_words = '{16'h0102, 16'h0304, 16'h0506};
    b2b_exp   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    // reset state
    #3;
    chk("rst_out_valid", outValid, 0);
    chk("rst_in_ready", inReady, 0);
    chk("rst_byte", outByte, 0);
    chk("rst_last", outLast, 0);
    chk("rst_count", wordCount, 0);
    #10 resetN = 1'b1;
    tick;
    // reset while a word is held under backpressure
    inValid = 1'b1; inWord = 16'hA55A; inMsbFirst = 1'b1; outReady = 1'b0;
    #1 chk("mid_in_ready", inReady, 1);
    tick;
    inValid = 1'b0;
    #1;
    chk("mid_out_valid", outValid, 1);
    chk("mid_byte", outByte, 8'hA5);
    #1 resetN = 1'b0;
    #1;
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_in_ready", inReady, 0);
    chk("mid_rst_count", wordCount, 0);
    chk("mid_rst_byte", outByte, 0);
    #2 resetN = 1'b1;
    tick;
    chk("post_rst_in_ready", inReady, 1);
    chk("post_rst_valid", outValid, 0);
    outReady = 1'b1;
    tick;
    chk("post_rst_no_stale", outValid, 0);
    chk("post_rst_byte", outByte, 0);
    // single words from the vector table
    for (int i = 0; i < 7; i++) begin
      inWord = vecs[i].w; inMsbFirst = vecs[i].msb; inValid = 1'b1; outReady = 1'b1;
      #1 chk("vec_in_ready_idle", inReady, 1);
      tick;
      inValid = 1'b0; inWord = 16'hDEAD; inMsbFirst = ~vecs[i].msb;
      #1;
      chk("vec_valid1", outValid, 1);
      chk("vec_byte1", outByte, vecs[i].b1);
      chk("vec_last1", outLast, 0);
      chk("vec_in_ready_first", inReady, 0);
`ifdef SPLIT_PARITY_EN
      chk("vec_parity1", outParity, vecs[i].p1);
`endif
      tick;
      chk("vec_byte2", outByte, vecs[i].b2);
      chk("vec_last2", outLast, 1);
      chk("vec_in_ready_second", inReady, 1);
      chk("vec_count_pending", wordCount, cnt);
`ifdef SPLIT_PARITY_EN
      chk("vec_parity2", outParity, vecs[i].p2);
`endif
      tick;
      cnt++;
      chk("vec_idle_valid", outValid, 0);
      chk("vec_idle_byte", outByte, 0);
      chk("vec_count", wordCount, cnt);
`ifdef SPLIT_PARITY_EN
      chk("vec_idle_parity", outParity, 0);
`endif
    end
    // LSB first with 3 stalled cycles on each byte
    inWord = 16'hBEEF; inMsbFirst = 1'b0; inValid = 1'b1; outReady = 1'b0;
    tick;
    inValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_byte1", outByte, 8'hEF);
      chk("bp_last1", outLast, 0);
      chk("bp_in_ready1", inReady, 0);
      tick;
    end
    outReady = 1'b1;
    tick;
    outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_byte2", outByte, 8'hBE);
      chk("bp_last2", outLast, 1);
      chk("bp_in_ready2", inReady, 0);
      tick;
    end
    outReady = 1'b1;
    #1 chk("bp_in_ready_release", inReady, 1);
    tick;
    cnt++;
    chk("bp_count", wordCount, cnt);
    chk("bp_idle", outValid, 0);
    // back-to-back words, no bubble
    prev = cnt;
    inWord = b2b_words[0]; inMsbFirst = 1'b1; inValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("b2b_valid", outValid, 1);
      chk("b2b_byte", outByte, b2b_exp[i]);
      chk("b2b_last", outLast, i % 2);
      if (i % 2 == 0) begin
        if (i / 2 + 1 < 3) inWord = b2b_words[i/2+1];
        else inValid = 1'b0;
      end
    end
    tick;
    cnt = cnt + 8'd3;
    chk("b2b_count", wordCount, cnt);
    chk("b2b_idle", outValid, 0);
    chk("b2b_count_delta", wordCount - prev, 3);
    // 256 streamed words: counter wraps through 255 -> 0
    inWord = 16'h5AA5; inValid = 1'b1; outReady = 1'b1;
    tick;
    for (int j = 1; j <= 256; j++) begin
      tick;
      chk("wrap_count_second", wordCount, cnt);
      if (j == 256) inValid = 1'b0;
      prev = cnt;
      tick;
      cnt++;
      chk("wrap_count", wordCount, cnt);
      if (prev == 8'hFF) chk("wrap_to_zero", wordCount, 0);
    end
    chk("wrap_idle", outValid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
